// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared bus command encodings, controller state type and
//                I/O address map for the mem_io_ctrl block.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    // CPU bus command encodings; 2'b11 is reserved and treated as an error
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Memory-mapped I/O locations
    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    // The lower half of the 9-bit space is the 256-word RAM
    function automatic logic is_ram_addr(input logic [8:0] addr);
        return ~addr[8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram256x16.sv
`default_nettype none
// ============================================================================
//  Module      : ram256x16
//  Description : 256 x 16 single-port synchronous RAM. The read address is
//                registered on an enabled cycle; data appears one cycle later.
//                Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ram256x16 (
    input  logic        clk,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [7:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [0:255];
    logic [7:0]  raddr_q;

    // Storage write and read-address capture
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            raddr_q <= addr_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];

endmodule
`default_nettype wire

// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_ctrl
//  Description : CPU bus controller for a 256x16 RAM plus LED (write) and
//                switch (read) registers. Handles address decode, completion
//                strobe and a sticky bus-error flag.
//  Config      : define SW_SYNC_EN to pass SW through a 2-flop synchronizer.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_io_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    input  logic [9:0]  SW,
    output logic [7:0]  LEDR,
    output logic        bus_err
);

    state_t      state_q;
    logic [15:0] read_data_q;
    logic        mem_ready_q;
    logic [7:0]  ledr_q;
    logic        bus_err_q;

    logic        addr_ram;
    logic        addr_led;
    logic        addr_sw;
    logic        addr_unmapped;
    logic        ram_we;
    logic        ram_re;
    logic [15:0] ram_rdata;
    logic [9:0]  sw_val;

    assign addr_ram      = is_ram_addr(mem_addr);
    assign addr_led      = (mem_addr == LED_ADDR);
    assign addr_sw       = (mem_addr == SW_ADDR);
    assign addr_unmapped = ~(addr_ram | addr_led | addr_sw);

    // RAM is only touched from IDLE, on the command-sample edge
    assign ram_we = (state_q == IDLE) && (mem_cmd == MWRITE) && addr_ram;
    assign ram_re = (state_q == IDLE) && (mem_cmd == MREAD)  && addr_ram;

`ifdef SW_SYNC_EN
    logic [9:0] sw_meta_q;
    logic [9:0] sw_sync_q;

    // Two-stage synchronizer for the asynchronous board switches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q <= 10'd0;
            sw_sync_q <= 10'd0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_val = sw_sync_q;
`else
    assign sw_val = SW;
`endif

    ram256x16 u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (mem_addr[7:0]),
        .wdata_i (write_data),
        .rdata_o (ram_rdata)
    );

    // Transaction FSM with registered read data, LEDs, strobe and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            read_data_q <= 16'h0000;
            mem_ready_q <= 1'b0;
            ledr_q      <= 8'h00;
            bus_err_q   <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (mem_cmd)
                        MNONE: begin
                            state_q <= IDLE;
                        end
                        MWRITE: begin
                            // RAM write is performed by the RAM itself via ram_we;
                            // a store to the switch register is silently dropped
                            if (addr_led) begin
                                ledr_q <= write_data[7:0];
                            end else if (addr_unmapped) begin
                                bus_err_q <= 1'b1;
                            end
                            state_q     <= DONE;
                            mem_ready_q <= 1'b1;
                        end
                        MREAD: begin
                            if (addr_ram) begin
                                state_q <= RD_WAIT;
                            end else begin
                                if (addr_led) begin
                                    read_data_q <= {8'h00, ledr_q};
                                end else if (addr_sw) begin
                                    read_data_q <= {6'b000000, sw_val};
                                end else begin
                                    read_data_q <= 16'h0000;
                                    bus_err_q   <= 1'b1;
                                end
                                state_q     <= DONE;
                                mem_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            // Reserved command: flag it and complete with no effect
                            bus_err_q   <= 1'b1;
                            state_q     <= DONE;
                            mem_ready_q <= 1'b1;
                        end
                    endcase
                end
                RD_WAIT: begin
                    read_data_q <= ram_rdata;
                    state_q     <= DONE;
                    mem_ready_q <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign LEDR      = ledr_q;
    assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have mem_cmd  in  2  CPU bus command: NONE/READ/WRITE, with 2'b11 reserved.
REQ-004 SHALL have mem_addr  in  9  CPU word address.
REQ-005 SHALL have write_data  in  16  CPU store data.
REQ-006 SHALL have read_data  out  16  load data returned to the CPU, registered.
REQ-007 SHALL have mem_ready  out  1  one-cycle completion strobe.
REQ-008 SHALL have SW  in  10  board switches.
REQ-009 SHALL have LEDR  out  8  board LEDs, registered.
REQ-010 SHALL have bus_err  out  1  sticky error flag.

Function
REQ-011 SHALL decode addresses as follows:
- 0x000-0x0FF (addr[8]=0): RAM, 256x16.
- 0x100: LEDR, write only; low 8 bits of write_data are used.
- 0x140: SW, read only; returns {6'b0,SW}.
- Any other address is unmapped.
REQ-012 SHALL run an FSM with states IDLE, RD_WAIT and DONE, and SHALL sample mem_cmd only in IDLE.
REQ-013 When IDLE sees WRITE, SHALL perform the RAM or LEDR write at that clock edge and move to DONE.
REQ-014 When IDLE sees READ to RAM, SHALL register the RAM address at that edge and move to RD_WAIT; at the next edge it SHALL load read_data from RAM and move to DONE.
REQ-015 When IDLE sees READ to SW or an unmapped address, SHALL load read_data ({6'b0,SW} or 16'h0000) at that edge and move to DONE.
REQ-016 SHALL drive mem_ready=1 exactly when state==DONE, and DONE SHALL always return to IDLE on the next edge.
- Latency from command-sample cycle to mem_ready: RAM read 2 cycles; write or IO read 1 cycle.
REQ-017 SHALL hold read_data stable until the next read completes; writes SHALL NOT change read_data.
REQ-018 On an unmapped-address access or a reserved command (2'b11), SHALL:
- set bus_err, which remains set until reset;
- ignore any write;
- complete as a 1-cycle transaction with mem_ready.
REQ-019 In IDLE, NONE SHALL cause no action and no mem_ready.
REQ-020 The CPU holds mem_cmd/mem_addr/write_data until mem_ready. A command still present in the cycle after DONE (back in IDLE) SHALL be treated as a new transaction.
REQ-021 A write to 0x140 (SW) SHALL be ignored without error. A read of 0x100 (LEDR) SHALL return {8'b0,LEDR} without error.
REQ-022 Addresses wrap at 9 bits; there SHALL be no carry or alias beyond the map in REQ-011.

Reset
REQ-023 Asserting reset SHALL asynchronously force: state=IDLE, read_data=16'h0000, mem_ready=0, LEDR=8'h00, bus_err=0.
REQ-024 Reset asserted mid-transaction SHALL abort it with no write and no mem_ready. RAM contents SHALL NOT be reset.

Configuration
REQ-025 With SW_SYNC_EN defined, SW SHALL pass through a 2-flop synchronizer (reset to 0) before read-mux use, so a switch change is visible to reads 2 cycles later.
REQ-026 Without SW_SYNC_EN, SW SHALL be read combinationally at the sample edge.

Structure
REQ-027 Package mem_pkg SHALL hold:
- mem_cmd encodings: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10;
- the FSM state enum;
- address constants LED_ADDR=9'h100 and SW_ADDR=9'h140.
REQ-028 SHALL instantiate one sub-module, ram256x16: single-port synchronous RAM with registered read address, write-enable and 1-cycle read latency. The controller holds the address-map decode and FSM.

Verification
REQ-029 After reset, SHALL show read_data=0, LEDR=0, bus_err=0 and mem_ready=0 for 5 idle cycles.
REQ-030 WRITE addr 0x005 data 16'hBEEF, then READ 0x005 -> mem_ready 1 cycle after the write sample; on the read, mem_ready 2 cycles after sample with read_data=16'hBEEF.
REQ-031 WRITE 0x100 data 16'h12A5 -> LEDR=8'hA5 one cycle later; read_data unchanged.
REQ-032 SW=10'h2C3, READ 0x140 -> read_data=16'h02C3 with mem_ready 1 cycle after sample; with SW_SYNC_EN, a SW change made 1 cycle before the sample is not yet reflected.
REQ-033 READ 0x1FF -> read_data=16'h0000, mem_ready after 1 cycle, bus_err=1 and staying 1. A subsequent valid RAM read still completes normally.
REQ-034 Assert reset in RD_WAIT during a RAM read -> no mem_ready pulse, state IDLE, read_data=0; a RAM word previously written is still readable after reset release.
